mult_seq: RTL and testbench

Multi-cycle radix-2 shift-add multiplier sequencer for the execute stage. It accepts a MULT operation from decode/execute control, holds the pipeline with `stall` while it iterates, then presents a 16-bit result with overflow flag in the same format the execute result mux consumes as `XOut`. It owns its own datapath and does not borrow the shared ALU, so execute can resume normal operation the cycle after `valid`.

---
 rtl/mult_seq.sv | 133 +++++++++++++
 tb/tb_mult_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// Multi-cycle radix-2 shift-add multiplier for the execute stage; stalls upstream while iterating.
// Define MULT_SIGNED_EN to honour `sign` (magnitude conversion + final negation); otherwise all unsigned.
module mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             kill,
    input  logic             sign,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             stall,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             ofl,
    output logic             err
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic                 load, step, last;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH:0]     acc, acc_nxt;
    logic [WIDTH-1:0]     mcand, mag_a, mag_b;
    logic                 neg, neg_in, sgn_q, sign_eff;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod;
    logic                 ofl_nxt;

    assign last = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        valid     = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        err       = start && (state != IDLE);
        case (state)
            IDLE: begin
                if (start && !kill) begin
                    load      = 1'b1;
                    stall     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                stall = 1'b1;
                if (kill) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (last) state_nxt = DONE;
                end
            end
            DONE: begin
                valid     = !kill;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MULT_SIGNED_EN
    assign sign_eff = sign;

    always_comb begin
        neg_in = sign_eff & (opA[WIDTH-1] ^ opB[WIDTH-1]);
        mag_a  = (sign_eff && opA[WIDTH-1]) ? -opA : opA;
        mag_b  = (sign_eff && opB[WIDTH-1]) ? -opB : opB;
    end
`else
    logic unused_sign;

    assign unused_sign = sign;
    assign sign_eff    = 1'b0;

    always_comb begin
        neg_in = 1'b0;
        mag_a  = opA;
        mag_b  = opB;
    end
`endif

    // Multiplier lives in the low half of acc and is consumed as the partial sum shifts in.
    always_comb begin
        sum     = acc[2*WIDTH:WIDTH] + {1'b0, (acc[0] ? mcand : '0)};
        acc_nxt = {1'b0, sum, acc[WIDTH-1:1]};
`ifdef MULT_SIGNED_EN
        prod    = neg ? -acc_nxt[2*WIDTH-1:0] : acc_nxt[2*WIDTH-1:0];
`else
        prod    = acc_nxt[2*WIDTH-1:0];
`endif
        ofl_nxt = sgn_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                        : (prod[2*WIDTH-1:WIDTH] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            neg    <= 1'b0;
            sgn_q  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            ofl    <= 1'b0;
        end else if (load) begin
            acc    <= {{(WIDTH+1){1'b0}}, mag_b};
            mcand  <= mag_a;
            neg    <= neg_in;
            sgn_q  <= sign_eff;
            cnt    <= CNT_W'(WIDTH-1);
        end else if (step) begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
            // Result registers on the final iteration so it is stable throughout DONE.
            if (last) begin
                result <= prod[WIDTH-1:0];
                ofl    <= ofl_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corners, kill/reset/protocol cases, randomized ops
// against an integer-arithmetic reference model (follows MULT_SIGNED_EN like the DUT).
module tb_mult_seq;

    localparam int W = 16;

`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, start, kill, sign;
    logic [W-1:0] opA, opB, result;
    logic         stall, valid, ofl, err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mult_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .kill   (kill),
        .sign   (sign),
        .opA    (opA),
        .opB    (opB),
        .stall  (stall),
        .valid  (valid),
        .result (result),
        .ofl    (ofl),
        .err    (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic void ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] r, output logic o);
        longint p;
        if (s && SIGNED_EN) begin
            p = longint'($signed(a)) * longint'($signed(b));
            o = (p < -32768) || (p > 32767);
        end else begin
            p = longint'(a) * longint'(b);
            o = (p > 65535);
        end
        r = p[W-1:0];
    endfunction

    // Called just after the start cycle's sample point; counts further stall cycles until valid.
    task automatic wait_valid(output int stall_cycles, output bit seen);
        stall_cycles = 0;
        seen         = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (valid) begin
                seen = 1'b1;
                break;
            end
            if (stall) stall_cycles++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int           sc;
        bit           seen;
        logic [W-1:0] r_exp;
        logic         o_exp;
        @(negedge clk);
        opA   = a;
        opB   = b;
        sign  = s;
        start = 1'b1;
        #1;
        check("valid_low_idle", valid, 0);
        check("stall_on_start", stall, 1);
        wait_valid(sc, seen);
        ref_mul(a, b, s, r_exp, o_exp);
        check($sformatf("valid_seen %h*%h s%0d", a, b, s), seen, 1);
        check("stall_cycles", sc + 1, 17);
        check($sformatf("result %h*%h s%0d", a, b, s), result, r_exp);
        check($sformatf("ofl %h*%h s%0d", a, b, s), ofl, o_exp);
        check("stall_in_done", stall, 0);
    endtask

    initial begin
        int           sc;
        bit           seen, seenv;
        logic [W-1:0] corners [5];
        logic [W-1:0] a, b;

        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        rst_n = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        sign  = 1'b0;
        opA   = '0;
        opB   = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_valid", valid, 0);
        check("rst_result", result, 0);
        check("rst_ofl", ofl, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corners
        run_op(16'h0003, 16'h0005, 1'b0);
        run_op(16'h0100, 16'h0100, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0);
        run_op(16'hFFF9, 16'h0003, 1'b1);
        run_op(16'h8000, 16'h0002, 1'b1);
        run_op(16'hFFFF, 16'h0002, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b1);
        run_op(16'h8000, 16'hFFFF, 1'b1);
        run_op(16'h0000, 16'hFFFF, 1'b1);
        run_op(16'hFFFF, 16'hFFFF, 1'b0);

        // Kill during RUN cycle 5
        @(negedge clk);
        opA = 16'h1234; opB = 16'h0002; sign = 1'b0; start = 1'b1;
        #1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 5) kill = 1'b1;
            #1;
        end
        check("kill_stall_in_run", stall, 1);
        @(negedge clk);
        kill = 1'b0;
        #1;
        check("kill_stall_after", stall, 0);
        check("kill_valid_after", valid, 0);
        seenv = 1'b0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (valid) seenv = 1'b1;
        end
        check("kill_no_valid", seenv, 0);
        run_op(16'h0002, 16'h0002, 1'b0);

        // Async reset during RUN cycle 8
        @(negedge clk);
        opA = 16'hABCD; opB = 16'h0123; sign = 1'b0; start = 1'b1;
        #1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_stall", stall, 0);
        check("midrst_valid", valid, 0);
        check("midrst_result", result, 0);
        check("midrst_ofl", ofl, 0);
        check("midrst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("postrst_idle", stall, 0);
        run_op(16'h0007, 16'h0009, 1'b0);

        // start while RUN: err flagged, operands not resampled
        @(negedge clk);
        opA = 16'h0003; opB = 16'h0007; sign = 1'b0; start = 1'b1;
        #1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            start = (i == 3);
            if (i == 3) begin
                opA = 16'hFFFF;
                opB = 16'hFFFF;
            end
            #1;
        end
        check("err_in_run", err, 1);
        check("err_stall", stall, 1);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("err_clears", err, 0);
        wait_valid(sc, seen);
        check("err_valid_seen", seen, 1);
        check("err_stall_cycles", sc + 5, 17);
        check("err_result_kept", result, 16'h0015);
        check("err_ofl_kept", ofl, 0);

        // Randomized operations, biased toward corner operands
        repeat (40) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            run_op(a, b, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
